itoa_writer: RTL and testbench
==============================

// Module: itoa_writer
// PURPOSE
//  Number-to-text emitter: converts a DSZ-bit data-stack value to ASCII
//    (decimal signed or hex unsigned) and writes it, most-significant digit
//    first plus one trailing space, into the terminal output buffer.
//  It is the output-side counterpart of the TIB number parser: it writes
//    where the parser reads. It is driven by the inner interpreter for '.'.
//  It owns one mb8_io master port. The outer level muxes that port onto the
//    shared memory block.
// PARAMETERS
//  MSZ    8   memory data width (one ASCII char per write)
//  DSZ    32  value width
//  ASZ    17  address width
//  NDIG   11  digit LIFO depth (max decimal digits of DSZ bits, +1)
// PORTS
//  clk    in   1      system clock
//  rst    in   1      asynchronous, active-high reset
//  en     in   1      request/hold: level-sensitive, and dropping it aborts
//  hex    in   1      1: unsigned hex, upper-case A-F; 0: signed decimal
//  vi     in   DSZ    value to print (sampled on start)
//  tob    in   ASZ    first output buffer address (sampled on start)
//  mb_if  mb8_io.master  drives we, ai[ASZ], vi[MSZ]; never reads memory
//  bsy    out  1      conversion or write in progress
//  len    out  8      chars written incl. trailing space (valid when done)
// BEHAVIOUR
//  Reset and idle values: bsy=0, len=0, mb_if.we=0, mb_if.ai=0, mb_if.vi=0.
//    Reset is asynchronous and may hit any state.
//  FSM states (itoa_sts): IDL, SGN, DIV, PSH, WR, SPC, DON.
//  IDL:
//    - If en=1, latch vi, hex and tob, set bsy=1 and go to SGN on the next edge.
//    - bsy rises on the edge after en is seen.
//  SGN:
//    - Decimal and vi[DSZ-1]=1: write '-' (0x2D) at tob, ptr=tob+1, mag=-vi as
//      unsigned. The most negative value is therefore exact.
//    - Otherwise: mag=vi, ptr=tob, no write.
//    - Next state: DIV.
//  DIV, decimal:
//    - Start udiv10 and wait for its done pulse (exactly DSZ cycles).
//    - Quotient goes to mag, remainder goes to the digit register.
//  DIV, hex: digit=mag[3:0], mag>>=4. Takes 1 cycle.
//  PSH:
//    - Push '0'+d (d<10) or 'A'+d-10 onto the digit LIFO.
//    - mag!=0: back to DIV. mag==0: go to WR.
//    - Zero input therefore yields exactly one digit, "0".
//  WR:
//    - Each cycle pop one digit: we=1, ai=ptr, vi=char; then ptr++.
//    - Go to SPC when the LIFO is empty.
//  SPC: we=1, ai=ptr, vi=0x20. len=ptr+1-tob. Next state: DON.
//  DON:
//    - bsy=0 and we=0. Stay in DON while en=1.
//    - en=0 returns to IDL. A new value needs en low for >=1 cycle.
//  Abort: en=0 in any non-IDL state:
//    - Next edge goes to IDL with bsy=0 and we=0.
//    - Bytes already written stay in memory. len is not updated.
//  Write strobes:
//    - we is high for exactly one cycle per character, at consecutive addresses.
//    - No write ever goes below tob or beyond tob+len-1.
//  Address arithmetic wraps modulo 2^ASZ with no error.
//  Latency from en to bsy falling:
//    - hex: 1 + 2n + n + 1 + 1, where n = digit count.
//    - decimal: 1 + n(DSZ+1) + n + [sign] + 1 + 1.
//  LIFO overflow cannot occur (NDIG sized for the worst case). An assertion
//    checks this.
// STRUCTURE
//  forthsuper.vh gets:
//    - typedef enum itoa_sts
//    - localparams ASC_0, ASC_A, ASC_MINUS, ASC_SPACE
//  Sub-module udiv10:
//    - sequential restoring divide-by-10
//    - ports: clk, rst, start, n[DSZ], q[DSZ], r[3:0], done
//    - 1 quotient bit per cycle, done pulses DSZ cycles after start
//  Digit LIFO: local array + pointer, no separate module.
// TESTING
//  vi=0, dec, tob=0x100 -> mem[100..101]="0 ", len=2.
//  vi=12345, dec -> "12345 " at tob, len=6, exactly 6 we pulses, ascending ai.
//  vi=-42 (0xFFFFFFD6), dec -> "-42 ", len=4.
//  vi=0x80000000, dec -> "-2147483648 ", len=12.
//  vi=0xDEADBEEF, hex=1 -> "DEADBEEF ", len=9; latency matches formula.
//  Interrupts:
//    - Drop en mid-DIV: bsy=0 next cycle, no further writes; a restart then
//      prints correctly.
//    - Assert rst mid-WR: we=0 immediately (async), all outputs at reset values.

Source files
------------

// File: rtl/itoa_writer_pkg.sv
// Shared types and character constants for the number-to-text emitter.
package itoa_writer_pkg;

    typedef enum logic [2:0] {IDL, SGN, DIV, PSH, WR, SPC, DON} itoa_sts;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    function automatic logic [7:0] dig2asc(input logic [3:0] d);
        return (d < 4'd10) ? (ASC_0 + {4'h0, d}) : (ASC_A + {4'h0, d} - 8'd10);
    endfunction

endpackage

// File: rtl/mb8_io.sv
// Byte-wide memory block port: one master drives write strobe, address and data.
interface mb8_io #(
    parameter int ASZ = 17,
    parameter int MSZ = 8
);
    logic           we;
    logic [ASZ-1:0] ai;
    logic [MSZ-1:0] vi;

    modport master (output we, ai, vi);
    modport slave  (input  we, ai, vi);
endinterface

// File: rtl/itoa_writer_udiv10.sv
// Sequential restoring divide-by-10, one quotient bit per cycle.
// The step on the start edge already consumes the first dividend bit, so done is seen in the DSZ-th cycle.
module itoa_writer_udiv10 #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DSZ-1:0] n,
    output logic [DSZ-1:0] q,
    output logic [3:0]     r,
    output logic           done
);
    localparam int CW = $clog2(DSZ + 1);

    logic [DSZ-1:0] q_q, q_d, src_q;
    logic [3:0]     r_q, r_d, src_r;
    logic [4:0]     part;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        src_r  = start ? 4'h0 : r_q;
        src_q  = start ? n : q_q;
        part   = {src_r, src_q[DSZ-1]};
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start || busy_q) begin
            if (part >= 5'd10) begin
                r_d = 4'(part - 5'd10);
                q_d = {src_q[DSZ-2:0], 1'b1};
            end else begin
                r_d = part[3:0];
                q_d = {src_q[DSZ-2:0], 1'b0};
            end
            cnt_d  = start ? CW'(1) : cnt_q + CW'(1);
            done_d = (cnt_d == CW'(DSZ));
            busy_d = !done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign done = done_q;

endmodule

// File: rtl/itoa_writer.sv
// Converts a data-stack value to ASCII (signed decimal or unsigned hex) and writes it,
// most-significant digit first plus a trailing space, through its byte memory port.
module itoa_writer
    import itoa_writer_pkg::*;
#(
    parameter int MSZ  = 8,
    parameter int DSZ  = 32,
    parameter int ASZ  = 17,
    parameter int NDIG = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [DSZ-1:0] vi,
    input  logic [ASZ-1:0] tob,
    mb8_io.master          mb_if,
    output logic           bsy,
    output logic [7:0]     len
);
    localparam int SPW = $clog2(NDIG + 1);

    itoa_sts        state_q, state_d;
    logic [DSZ-1:0] val_q, val_d, mag_q, mag_d;
    logic           hex_q, hex_d;
    logic [ASZ-1:0] tob_q, tob_d, ptr_q, ptr_d;
    logic [3:0]     dig_q, dig_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           we_q, we_d;
    logic [ASZ-1:0] ai_q, ai_d;
    logic [MSZ-1:0] wd_q, wd_d;
    logic           bsy_q, bsy_d;
    logic [7:0]     len_q, len_d;

    logic [MSZ-1:0] lifo_q [NDIG];
    logic           push;
    logic [MSZ-1:0] push_chr;
    logic           neg;
    logic           div_start, div_done;
    logic [DSZ-1:0] div_q;
    logic [3:0]     div_r;

    assign neg = !hex_q && val_q[DSZ-1];

    itoa_writer_udiv10 #(.DSZ(DSZ)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .n     (mag_d),
        .q     (div_q),
        .r     (div_r),
        .done  (div_done)
    );

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        hex_d     = hex_q;
        tob_d     = tob_q;
        ptr_d     = ptr_q;
        mag_d     = mag_q;
        dig_d     = dig_q;
        sp_d      = sp_q;
        bsy_d     = bsy_q;
        len_d     = len_q;
        we_d      = 1'b0;
        ai_d      = '0;
        wd_d      = '0;
        push      = 1'b0;
        push_chr  = MSZ'(dig2asc(dig_q));
        div_start = 1'b0;

        // Bus registers are loaded on the edge entering the state that owns the write,
        // so each strobe lines up with SGN/WR/SPC rather than trailing by a cycle.
        case (state_q)
            IDL: if (en) begin
                val_d   = vi;
                hex_d   = hex;
                tob_d   = tob;
                sp_d    = '0;
                bsy_d   = 1'b1;
                state_d = SGN;
            end
            SGN: if (neg && !we_q) begin
                we_d = 1'b1;
                ai_d = tob_q;
                wd_d = MSZ'(ASC_MINUS);
            end else begin
                mag_d     = neg ? (~val_q + DSZ'(1)) : val_q;
                ptr_d     = neg ? (tob_q + ASZ'(1)) : tob_q;
                div_start = !hex_q;
                state_d   = DIV;
            end
            DIV: if (hex_q) begin
                dig_d   = mag_q[3:0];
                mag_d   = mag_q >> 4;
                state_d = PSH;
            end else if (div_done) begin
                dig_d   = div_r;
                mag_d   = div_q;
                state_d = PSH;
            end
            PSH: if (mag_q != '0) begin
                push      = 1'b1;
                sp_d      = sp_q + SPW'(1);
                div_start = !hex_q;
                state_d   = DIV;
            end else begin
                // The most-significant digit goes straight to the bus instead of the LIFO.
                we_d    = 1'b1;
                ai_d    = ptr_q;
                wd_d    = push_chr;
                ptr_d   = ptr_q + ASZ'(1);
                state_d = WR;
            end
            WR: if (sp_q != '0) begin
                we_d  = 1'b1;
                ai_d  = ptr_q;
                wd_d  = lifo_q[sp_q - SPW'(1)];
                sp_d  = sp_q - SPW'(1);
                ptr_d = ptr_q + ASZ'(1);
            end else begin
                we_d    = 1'b1;
                ai_d    = ptr_q;
                wd_d    = MSZ'(ASC_SPACE);
                len_d   = 8'(ptr_q + ASZ'(1) - tob_q);
                state_d = SPC;
            end
            SPC: begin
                bsy_d   = 1'b0;
                state_d = DON;
            end
            DON: ;
            default: state_d = IDL;
        endcase

        if (state_q != IDL && !en) begin
            state_d   = IDL;
            bsy_d     = 1'b0;
            len_d     = len_q;
            we_d      = 1'b0;
            ai_d      = '0;
            wd_d      = '0;
            push      = 1'b0;
            div_start = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDL;
            val_q   <= '0;
            hex_q   <= 1'b0;
            tob_q   <= '0;
            ptr_q   <= '0;
            mag_q   <= '0;
            dig_q   <= '0;
            sp_q    <= '0;
            we_q    <= 1'b0;
            ai_q    <= '0;
            wd_q    <= '0;
            bsy_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            hex_q   <= hex_d;
            tob_q   <= tob_d;
            ptr_q   <= ptr_d;
            mag_q   <= mag_d;
            dig_q   <= dig_d;
            sp_q    <= sp_d;
            we_q    <= we_d;
            ai_q    <= ai_d;
            wd_q    <= wd_d;
            bsy_q   <= bsy_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) lifo_q[sp_q] <= push_chr;
    end

    lifo_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (sp_q < SPW'(NDIG)));

    assign mb_if.we = we_q;
    assign mb_if.ai = ai_q;
    assign mb_if.vi = wd_q;
    assign bsy      = bsy_q;
    assign len      = len_q;

endmodule

// File: tb/tb_itoa_writer.sv
// Scoreboard bench for itoa_writer: expected bytes queued at issue, popped by a write monitor.
module tb_itoa_writer;
    localparam int MSZ  = 8;
    localparam int DSZ  = 32;
    localparam int ASZ  = 17;
    localparam int NDIG = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic           hex = 1'b0;
    logic [DSZ-1:0] vi  = '0;
    logic [ASZ-1:0] tob = '0;
    logic           bsy;
    logic [7:0]     len;

    mb8_io #(.ASZ(ASZ), .MSZ(MSZ)) mb_if ();

    itoa_writer #(.MSZ(MSZ), .DSZ(DSZ), .ASZ(ASZ), .NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .hex   (hex),
        .vi    (vi),
        .tob   (tob),
        .mb_if (mb_if),
        .bsy   (bsy),
        .len   (len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ASZ-1:0] a;
        logic [7:0]     c;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  last_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mb_if.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("stray_write", 64'(mb_if.we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mb_if.ai), 64'(mon_e.a));
                chk("wr_char", 64'(mb_if.vi), 64'(mon_e.c));
            end
        end
    end

    // Reference: text by repeated division, then expected bytes and cycle count.
    task automatic expect_str(input logic [DSZ-1:0] v, input logic h, input logic [ASZ-1:0] t,
                              output int n_chars, output int exp_lat);
        string   digs;
        string   s;
        longint  m;
        int      base;
        int      nd;
        bit      neg;
        wr_t     w;
        digs = "0123456789ABCDEF";
        neg  = !h && v[DSZ-1];
        base = h ? 16 : 10;
        m    = h ? longint'({32'b0, v}) : longint'($signed(v));
        if (m < 0) m = -m;
        s = "";
        do begin
            s = {digs.substr(int'(m % base), int'(m % base)), s};
            m = m / base;
        end while (m != 0);
        nd = s.len();
        if (neg) s = {"-", s};
        s = {s, " "};
        for (int i = 0; i < s.len(); i++) begin
            w.a = t + ASZ'(i);
            w.c = s[i];
            exp_q.push_back(w);
        end
        n_chars = s.len();
        exp_lat = h ? (3 * nd + 3) : (nd * (DSZ + 1) + nd + (neg ? 1 : 0) + 3);
    endtask

    task automatic run(input logic [DSZ-1:0] v, input logic h, input logic [ASZ-1:0] t, input string tag);
        int nch, lat, cyc;
        @(negedge clk);
        vi = v; hex = h; tob = t; en = 1'b1;
        expect_str(v, h, t, nch, lat);
        @(posedge clk); #1;
        chk({tag, "_bsy_rise"}, 64'(bsy), 64'd1);
        cyc = 1;
        while (bsy && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_len"}, 64'(len), 64'(nch));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_don_idle"}, 64'({bsy, mb_if.we}), 64'd0);
        chk({tag, "_all_written"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        last_len = nch;
        @(negedge clk) en = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int nch, lat, cyc;
        logic [DSZ-1:0] rv;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bsy", 64'(bsy), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_we", 64'(mb_if.we), 64'd0);
        chk("rst_ai", 64'(mb_if.ai), 64'd0);
        chk("rst_vi", 64'(mb_if.vi), 64'd0);
        @(negedge clk) rst = 1'b0;

        run(32'd0,          1'b0, 17'h00100, "dec_zero");
        run(32'd12345,      1'b0, 17'h00200, "dec_12345");
        run(32'hFFFFFFD6,   1'b0, 17'h00300, "dec_m42");
        run(32'h80000000,   1'b0, 17'h00400, "dec_minint");
        run(32'hDEADBEEF,   1'b1, 17'h00500, "hex_deadbeef");
        run(32'd0,          1'b1, 17'h00580, "hex_zero");
        run(32'hFFFFFFFF,   1'b0, 17'h005A0, "dec_m1");
        run(32'd4294967295 >> 1, 1'b0, 17'h005C0, "dec_maxpos");
        run(32'd12345,      1'b0, 17'h1FFFD, "dec_wrap");

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: rv = 32'($urandom_range(0, 15));
                1: rv = 32'($urandom);
                2: rv = 32'(-$urandom_range(1, 1000));
                default: rv = 32'($urandom) & 32'h0000FFFF;
            endcase
            run(rv, 1'($urandom_range(0, 1)), 17'($urandom_range(0, 131071)), "rand");
        end

        // Abort during the first division: no writes, len untouched, then a clean restart.
        @(negedge clk);
        vi = 32'd123456789; hex = 1'b0; tob = 17'h00600; en = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("abort_bsy_before", 64'(bsy), 64'd1);
        @(negedge clk) en = 1'b0;
        @(posedge clk); #1;
        chk("abort_bsy", 64'(bsy), 64'd0);
        chk("abort_we", 64'(mb_if.we), 64'd0);
        repeat (40) @(posedge clk);
        #1 chk("abort_len", 64'(len), 64'(last_len));
        run(32'd123456789, 1'b0, 17'h00600, "restart");

        // Asynchronous reset while digits are being written.
        @(negedge clk);
        vi = 32'd987654; hex = 1'b0; tob = 17'h00040; en = 1'b1;
        expect_str(32'd987654, 1'b0, 17'h00040, nch, lat);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (mb_if.we) break;
        end
        chk("wr_reached", 64'(mb_if.we), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 64'(mb_if.we), 64'd0);
        chk("arst_ai", 64'(mb_if.ai), 64'd0);
        chk("arst_vi", 64'(mb_if.vi), 64'd0);
        chk("arst_bsy", 64'(bsy), 64'd0);
        chk("arst_len", 64'(len), 64'd0);
        exp_q.delete();
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        run(32'd99, 1'b1, 17'h00700, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
